rv32m_iter_unit: RTL and testbench
==================================

Name: rv32m_iter_unit

Overview:
- Iterative RV32M multiply/divide unit for the LagartoII core.
- Consumes the register-file read data (rs1/rs2) for M-extension instructions.
- Produces a one-cycle write request (data, rd address, write enable) that muxes into the register-file write port.
- The core stalls its PC/fetch while busy_o is high.

Parameters:
XLEN  32  operand/result width; iteration count equals XLEN
ADDRW  5  register address width

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request, sampled only in IDLE
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data_i  input  XLEN  operand A (multiplicand/dividend)
rs2_data_i  input  XLEN  operand B (multiplier/divisor)
rd_addr_i  input  ADDRW  destination register
busy_o  output  1  high in CALC and FINAL
done_o  output  1  high for exactly one cycle, in DONE
we_o  output  1  done_o AND (rd_addr_o != 0)
rd_addr_o  output  ADDRW  latched rd_addr_i
result_o  output  XLEN  registered result; holds until next FINAL

Behaviour:
- Clock is clk_i; reset is asynchronous, active-low on rst_ni.
- Reset (any time, including mid-CALC):
  - state IDLE; all registers, counter, result_o, rd_addr_o cleared to 0.
  - busy_o, done_o, we_o = 0.
  - The in-flight operation is discarded; no write is issued.
- States:
  - IDLE: on start_i, latch funct3, rd_addr, operand magnitudes and sign flags. Next state is FINAL if the op is a special-case divide, else CALC with counter = 0.
  - CALC: one iteration per edge. Counter increments. After iteration XLEN-1 (counter = 31), go to FINAL.
  - FINAL: apply sign correction, select low/high/quotient/remainder into result_o, go to DONE.
  - DONE: done_o = 1, we_o per rd; unconditionally return to IDLE. start_i is ignored here.
- start_i is ignored in CALC, FINAL and DONE; the operands are not re-sampled.
- Latency, start sampled at edge n:
  - Normal ops: CALC iterations at edges n+1..n+32; FINAL at edge n+33; done_o high between edges n+33 and n+34.
  - Special cases: FINAL at edge n+1; done_o high between edges n+1 and n+2.
- Multiply (shift-add on magnitudes, 2*XLEN-bit product):
  - Signedness: MUL/MULH treat both operands signed; MULHSU treats rs1 signed and rs2 unsigned; MULHU treats both unsigned.
  - Product is negated in FINAL when the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide (restoring, magnitudes):
  - Quotient is negated when the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - DIVU/REMU are unsigned.
- Special cases, decided at start and skipping CALC:
  - Divisor = 0: quotient = all ones; remainder = rs1_data_i unchanged.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Width rules: all arithmetic is modulo 2^XLEN (or 2^(2*XLEN) for the product); no exceptions or flags.
- Operand capture: inputs may change freely after the start cycle, since the operands are registered at start.
- rd = x0: the operation runs fully and done_o pulses, but we_o stays 0.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> done_o at start+33 cycles, we_o=1, rd_addr_o=5, result_o=0xFFFFFFEB; busy_o high for exactly 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REM 0x1234/0 -> 0x1234, each with done_o 1 cycle after FINAL (start+1); DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of same -> 0.
- Assert rst_ni low at CALC counter=10 -> all outputs 0 immediately (asynchronous); no done_o/we_o afterwards. The next start runs normally.
- start_i held high through an entire op with changing operands -> exactly one done pulse using the first operands. A second start is accepted only once the unit is back in IDLE; rd=0 op gives done_o=1, we_o=0.

Source files
------------

// File: rtl/rv32m_iter_unit.sv
// rv32m_iter_unit: iterative RV32M multiply/divide unit for the LagartoII core.
// Multiplies use a radix-2 shift-add over operand magnitudes. Divides use a
// restoring algorithm over magnitudes. Signs are fixed up in FINAL.
// Divide-by-zero and signed overflow are resolved at start and skip CALC.
// The product/remainder (hi) and multiplier/dividend/quotient (lo) share one
// double-width register pair.

module rv32m_iter_unit #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [ADDRW-1:0] rd_addr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             we_o,
    output logic [ADDRW-1:0] rd_addr_o,
    output logic [XLEN-1:0]  result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FINAL,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       op_q;
    logic [ADDRW-1:0] rd_q;
    logic [CW-1:0]    count_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  opnd_q;
    logic             neg_main_q;
    logic             neg_rem_q;

    // Decode of the incoming request, used only while idle
    logic            is_div_in;
    logic            a_signed_in, b_signed_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_zero_in, div_ovf_in, special_in;

    // Per-iteration datapath results
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_nxt, mul_lo_nxt;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   div_hi_nxt, div_lo_nxt;
    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   final_result;

    // Classify the requested op: operand signedness, magnitudes and special divides
    always_comb begin
        is_div_in   = funct3_i[2];
        a_signed_in = is_div_in ? ~funct3_i[0] : (funct3_i != 3'b011);
        b_signed_in = is_div_in ? ~funct3_i[0] : ~funct3_i[1];
        a_neg_in    = a_signed_in & rs1_data_i[XLEN-1];
        b_neg_in    = b_signed_in & rs2_data_i[XLEN-1];
        a_mag_in    = a_neg_in ? -rs1_data_i : rs1_data_i;
        b_mag_in    = b_neg_in ? -rs2_data_i : rs2_data_i;
        div_zero_in = is_div_in && (rs2_data_i == '0);
        div_ovf_in  = is_div_in && !funct3_i[0] &&
                      (rs1_data_i == INT_MIN) && (rs2_data_i == ALL_ONES);
        special_in  = div_zero_in | div_ovf_in;
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_nxt = mul_sum[XLEN:1];
        mul_lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};

        div_shift  = {hi_q, lo_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, opnd_q};
        if (!div_diff[XLEN]) begin
            div_hi_nxt = div_diff[XLEN-1:0];
            div_lo_nxt = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            div_hi_nxt = div_shift[XLEN-1:0];
            div_lo_nxt = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and selection of the architectural result
    always_comb begin
        product  = {hi_q, lo_q};
        prod_fix = neg_main_q ? -product : product;
        quot_fix = neg_main_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -hi_q : hi_q;
        case (op_q)
            3'b000:                 final_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_result = quot_fix;
            default:                final_result = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = special_in ? ST_FINAL : ST_CALC;
                end
            end
            ST_CALC: begin
                if (count_q == LAST_ITER) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy_o = (state_q == ST_CALC) || (state_q == ST_FINAL);
        done_o = (state_q == ST_DONE);
        we_o   = (state_q == ST_DONE) && (rd_q != '0);
    end

    assign rd_addr_o = rd_q;

    // Operand capture, iteration and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_o   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q    <= funct3_i;
                        rd_q    <= rd_addr_i;
                        count_q <= '0;
                        if (div_zero_in) begin
                            hi_q       <= rs1_data_i;
                            lo_q       <= ALL_ONES;
                            opnd_q     <= '0;
                            neg_main_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end else if (div_ovf_in) begin
                            hi_q       <= '0;
                            lo_q       <= INT_MIN;
                            opnd_q     <= '0;
                            neg_main_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end else begin
                            hi_q       <= '0;
                            lo_q       <= is_div_in ? a_mag_in : b_mag_in;
                            opnd_q     <= is_div_in ? b_mag_in : a_mag_in;
                            neg_main_q <= a_neg_in ^ b_neg_in;
                            neg_rem_q  <= is_div_in & a_neg_in;
                        end
                    end
                end
                ST_CALC: begin
                    count_q <= count_q + CW'(1);
                    if (op_q[2]) begin
                        hi_q <= div_hi_nxt;
                        lo_q <= div_lo_nxt;
                    end else begin
                        hi_q <= mul_hi_nxt;
                        lo_q <= mul_lo_nxt;
                    end
                end
                ST_FINAL: begin
                    result_o <= final_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_iter_unit.sv
// tb_rv32m_iter_unit: directed table, hand-written corner sequences and
// random ops checked against an arithmetic reference model.

module tb_rv32m_iter_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_addr;
    logic        busy, done, we;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t table_q[$];

    rv32m_iter_unit #(.XLEN(32), .ADDRW(5)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .funct3_i   (funct3),
        .rs1_data_i (rs1),
        .rs2_data_i (rs2),
        .rd_addr_i  (rd_addr),
        .busy_o     (busy),
        .done_o     (done),
        .we_o       (we),
        .rd_addr_o  (rd_out),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    // Architectural RV32M result computed with wide integer arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = 64'(sa * sb); return p[31:0];  end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Starting from the sample just after the start edge, wait for done
    task automatic waitDone(output int lat, output int busyCnt);
        lat     = -1;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busyCnt++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp, input int expLat);
        int lat, busyCnt;
        @(negedge clk);
        start   = 1'b1;
        funct3  = f3;
        rs1     = a;
        rs2     = b;
        rd_addr = rd;
        @(negedge clk);
        start   = 1'b0;
        funct3  = 3'($urandom);
        rs1     = $urandom;
        rs2     = $urandom;
        rd_addr = 5'($urandom);
        waitDone(lat, busyCnt);
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        if (lat >= 0) begin
            checkOutput({name, " result"}, result, exp);
            checkOutput({name, " we"}, 32'(we), 32'(rd != 0));
            checkOutput({name, " rd"}, 32'(rd_out), 32'(rd));
            checkOutput({name, " busy cycles"}, 32'(busyCnt), 32'(expLat));
            @(negedge clk);
            checkOutput({name, " done pulse width"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, busyCnt, seen;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;

        rst_n   = 1'b0;
        start   = 1'b0;
        funct3  = '0;
        rs1     = '0;
        rs2     = '0;
        rd_addr = '0;

        table_q.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33});
        table_q.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33});
        table_q.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33});
        table_q.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33});
        table_q.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33});
        table_q.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33});
        table_q.push_back('{3'b111, 32'd100,        32'd7,         5'd11, 32'd2,         33});
        table_q.push_back('{3'b101, 32'h0000_1234,  32'd0,         5'd12, 32'hFFFF_FFFF, 1});
        table_q.push_back('{3'b110, 32'h0000_1234,  32'd0,         5'd13, 32'h0000_1234, 1});
        table_q.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1});
        table_q.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1});
        table_q.push_back('{3'b000, 32'd3,          32'd5,         5'd0,  32'd15,        33});
        table_q.push_back('{3'b101, 32'd100,        32'd7,         5'd31, 32'd14,        33});

        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset we", 32'(we), 32'd0);
        checkOutput("reset rd", 32'(rd_out), 32'd0);
        checkOutput("reset result", result, 32'd0);
        rst_n = 1'b1;

        // Directed table
        foreach (table_q[i]) begin
            applyStimulus($sformatf("vec%0d", i), table_q[i].f3, table_q[i].a, table_q[i].b,
                          table_q[i].rd, table_q[i].exp, table_q[i].lat);
        end

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start   = 1'b1;
        funct3  = 3'b000;
        rs1     = 32'd1234;
        rs2     = 32'd5678;
        rd_addr = 5'd9;
        @(negedge clk);
        start   = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset we", 32'(we), 32'd0);
        checkOutput("midreset rd", 32'(rd_out), 32'd0);
        checkOutput("midreset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || we || busy) seen = 1;
        end
        checkOutput("midreset no activity", 32'(seen), 32'd0);
        applyStimulus("post reset", 3'b000, 32'd1234, 32'd5678, 5'd4,
                      refModel(3'b000, 32'd1234, 32'd5678), 33);

        // start held high with changing operands: one op per visit to IDLE
        @(negedge clk);
        start   = 1'b1;
        funct3  = 3'b100;
        rs1     = 32'hFFFF_FF9C;
        rs2     = 32'd7;
        rd_addr = 5'd12;
        lat     = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            funct3  = 3'($urandom);
            rs1     = $urandom;
            rs2     = $urandom | 32'd1;
            rd_addr = 5'($urandom);
        end
        checkOutput("held start latency", 32'(lat), 32'd33);
        checkOutput("held start result", result, 32'hFFFF_FFF2);
        checkOutput("held start we", 32'(we), 32'd1);
        checkOutput("held start rd", 32'(rd_out), 32'd12);
        funct3  = 3'b011;
        rs1     = 32'hFFFF_FFFF;
        rs2     = 32'hFFFF_FFFF;
        rd_addr = 5'd0;
        @(negedge clk);
        checkOutput("held start single pulse", 32'(done), 32'd0);
        checkOutput("held start idle", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("second start accepted", 32'(busy), 32'd1);
        waitDone(lat, busyCnt);
        checkOutput("second op latency", 32'(lat), 32'd33);
        checkOutput("second op result", result, 32'hFFFF_FFFE);
        checkOutput("second op rd0 we", 32'(we), 32'd0);
        checkOutput("second op rd0 done", 32'(done), 32'd1);

        // Random ops against the reference model
        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            rd = 5'($urandom_range(0, 31));
            applyStimulus($sformatf("rand%0d f3=%0d a=%08h b=%08h", n, f3, a, b), f3, a, b, rd,
                          refModel(f3, a, b), refLatency(f3, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
